// File: rtl/mpt_walk_arbiter.sv
// Round-robin arbiter that time-shares a single MPT page-table walker between
// NUM_REQ requesters, sequencing issue/wait/response and handling flush and bypass.
module mpt_walk_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int SPA_W          = 34,
  parameter int PLB_W          = 64,
  parameter int FMT_W          = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     mpt_en_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*SPA_W-1:0] req_spa_i,
  input  logic [NUM_REQ*2-1:0]     req_access_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic                     rsp_allow_o,
  output logic                     rsp_fault_o,
  output logic                     rsp_timeout_o,
  output logic [FMT_W-1:0]         rsp_format_err_o,
  output logic [PLB_W-1:0]         rsp_plb_entry_o,
  output logic                     ptw_flush_o,
  output logic                     ptw_enable_o,
  output logic                     ptw_addr_valid_o,
  output logic [SPA_W-1:0]         ptw_spa_o,
  output logic [1:0]               ptw_access_o,
  input  logic                     ptw_busy_i,
  input  logic                     ptw_valid_i,
  input  logic                     ptw_fault_i,
  input  logic [FMT_W-1:0]         ptw_format_err_i,
  input  logic                     ptw_allow_i,
  input  logic [PLB_W-1:0]         ptw_plb_entry_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, gnt_q, gnt_idx;
  logic [SPA_W-1:0]   spa_q;
  logic [1:0]         acc_q;
  logic [7:0]         cnt_q;
  logic               allow_q, fault_q, timeout_q, to_pulse_q;
  logic [FMT_W-1:0]   fmt_q;
  logic [PLB_W-1:0]   plb_q;
  logic               found, accept, complete, timeout_hit;
  logic               addr_valid, enable;
  logic [SPA_W-1:0]   spa_arr [NUM_REQ];
  logic [1:0]         acc_arr [NUM_REQ];
  logic               unused_busy;

  // The walker's busy flag is redundant with our own state tracking.
  assign unused_busy = ptw_busy_i;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign spa_arr[gi] = req_spa_i[gi*SPA_W +: SPA_W];
    assign acc_arr[gi] = req_access_i[gi*2 +: 2];
  end

  always_comb begin
    int unsigned cand;
    found   = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_q) + k) % NUM_REQ;
      if (!found && req_valid_i[cand]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    accept      = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    addr_valid  = 1'b0;
    enable      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush_i && found) begin
          accept               = 1'b1;
          req_ready_o[gnt_idx] = 1'b1;
          state_d              = mpt_en_i ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        addr_valid = !flush_i;
        enable     = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        enable = 1'b1;
        if (ptw_valid_i || ptw_fault_i || (ptw_format_err_i != '0)) begin
          complete = !flush_i;
          state_d  = RESP;
        end else if (cnt_q >= CNT_LAST) begin
          // This is the TIMEOUT_CYCLES-th silent WAIT cycle.
          timeout_hit = !flush_i;
          state_d     = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i && state_q != IDLE) state_d = IDLE;
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == RESP && !flush_i) rsp_valid_o[gnt_q] = 1'b1;
  end

  assign ptw_flush_o      = flush_i | to_pulse_q;
  assign ptw_enable_o     = enable;
  assign ptw_addr_valid_o = addr_valid;
  assign ptw_spa_o        = spa_q;
  assign ptw_access_o     = acc_q;
  assign rsp_allow_o      = allow_q;
  assign rsp_fault_o      = fault_q;
  assign rsp_timeout_o    = timeout_q;
  assign rsp_format_err_o = fmt_q;
  assign rsp_plb_entry_o  = plb_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_q       <= IDX_W'(NUM_REQ - 1);
      gnt_q      <= '0;
      spa_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      allow_q    <= 1'b0;
      fault_q    <= 1'b0;
      timeout_q  <= 1'b0;
      to_pulse_q <= 1'b0;
      fmt_q      <= '0;
      plb_q      <= '0;
    end else begin
      state_q    <= state_d;
      to_pulse_q <= timeout_hit;
      if (accept) begin
        gnt_q <= gnt_idx;
        rr_q  <= gnt_idx;
        spa_q <= spa_arr[gnt_idx];
        acc_q <= acc_arr[gnt_idx];
        if (!mpt_en_i) begin
          // Bypass: MPT disabled means every access is allowed.
          allow_q   <= 1'b1;
          fault_q   <= 1'b0;
          timeout_q <= 1'b0;
          fmt_q     <= '0;
          plb_q     <= '0;
        end
      end
      if (state_q == ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == WAIT && cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (complete) begin
        allow_q   <= ptw_allow_i & ~ptw_fault_i;
        fault_q   <= ptw_fault_i;
        timeout_q <= 1'b0;
        fmt_q     <= ptw_format_err_i;
        plb_q     <= ptw_plb_entry_i;
      end
      if (timeout_hit) begin
        allow_q   <= 1'b0;
        fault_q   <= 1'b1;
        timeout_q <= 1'b1;
        fmt_q     <= '0;
        plb_q     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mpt_walk_arbiter.sv
// Scoreboard bench for mpt_walk_arbiter: a walker model and the directed tests push
// expected grants/responses; a negedge monitor pops and compares them.
module tb_mpt_walk_arbiter;

  localparam int NR = 2;
  localparam int SW = 34;
  localparam int PW = 64;
  localparam int FW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            mpt_en = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*SW-1:0] req_spa = '0;
  logic [NR*2-1:0] req_access = '0;
  logic [NR-1:0]   rsp_valid;
  logic            rsp_allow, rsp_fault, rsp_timeout;
  logic [FW-1:0]   rsp_fmt;
  logic [PW-1:0]   rsp_plb;
  logic            ptw_flush, ptw_enable, ptw_addr_valid;
  logic [SW-1:0]   ptw_spa;
  logic [1:0]      ptw_access;
  logic            ptw_valid = 1'b0, ptw_fault = 1'b0, ptw_allow = 1'b0;
  logic [FW-1:0]   ptw_fmt = '0;
  logic [PW-1:0]   ptw_plb = '0;

  mpt_walk_arbiter #(.NUM_REQ(NR), .SPA_W(SW), .PLB_W(PW), .FMT_W(FW), .TIMEOUT_CYCLES(255)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .mpt_en_i(mpt_en),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_spa_i(req_spa),
    .req_access_i(req_access), .rsp_valid_o(rsp_valid), .rsp_allow_o(rsp_allow),
    .rsp_fault_o(rsp_fault), .rsp_timeout_o(rsp_timeout), .rsp_format_err_o(rsp_fmt),
    .rsp_plb_entry_o(rsp_plb), .ptw_flush_o(ptw_flush), .ptw_enable_o(ptw_enable),
    .ptw_addr_valid_o(ptw_addr_valid), .ptw_spa_o(ptw_spa), .ptw_access_o(ptw_access),
    .ptw_busy_i(1'b0), .ptw_valid_i(ptw_valid), .ptw_fault_i(ptw_fault),
    .ptw_format_err_i(ptw_fmt), .ptw_allow_i(ptw_allow), .ptw_plb_entry_i(ptw_plb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        allow, fault, tmo;
    logic [FW-1:0] fmt;
    logic [PW-1:0] plb;
    int          cyc;      // -1: arrival cycle not checked
    bit          chk_data; // compare fmt/plb
  } exp_t;

  exp_t rsp_q[$];
  int   grant_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   last_grant = 0;
  int   rsp_seen = 0, addrv_cnt = 0, flush_pulses = 0;
  bit   inflight = 0;

  // Walker model configuration, set by the tests before a walk is issued.
  int          w_delay = 1;
  bit          w_silent = 0;
  logic        w_valid = 1, w_fault = 0, w_allow = 1;
  logic [FW-1:0] w_fmt = '0;
  logic [PW-1:0] w_plb = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  // Walker model: completes each issued walk w_delay WAIT cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ptw_addr_valid && !w_silent) begin
        exp_t e;
        int   d;
        d = w_delay;
        e.idx = last_grant;
        repeat (d) @(posedge clk);
        #1;
        ptw_valid = w_valid; ptw_fault = w_fault; ptw_allow = w_allow;
        ptw_fmt = w_fmt; ptw_plb = w_plb;
        e.allow = w_allow & ~w_fault;
        e.fault = w_fault;
        e.tmo = 1'b0;
        e.fmt = w_fmt;
        e.plb = w_plb;
        e.cyc = cyc + 1;
        e.chk_data = 1;
        rsp_q.push_back(e);
        @(posedge clk);
        #1;
        ptw_valid = 0; ptw_fault = 0; ptw_allow = 0; ptw_fmt = '0; ptw_plb = '0;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      inflight = 0;
    end else begin
      if (req_ready != '0) begin
        if (grant_q.size() == 0) bound_fail("grant_unexpected");
        else begin
          int g;
          g = grant_q.pop_front();
          chk("req_ready", 64'(req_ready), 64'(1 << g));
          last_grant = g;
          $display("grant: req_ready=%b at cycle %0d", req_ready, cyc);
        end
      end
      if (ptw_addr_valid) begin
        chk("no_overlap", 64'(inflight), 64'd0);
        inflight = 1;
        addrv_cnt++;
      end
      if (flush) inflight = 0;
      if (ptw_flush && !flush) flush_pulses++;
      if (rsp_valid != '0) begin
        inflight = 0;
        rsp_seen++;
        if (rsp_q.size() == 0) bound_fail("rsp_unexpected");
        else begin
          exp_t e;
          e = rsp_q.pop_front();
          $display("rsp: valid=%b allow=%b fault=%b tmo=%b fmt=%0d plb=0x%0h at cycle %0d",
                   rsp_valid, rsp_allow, rsp_fault, rsp_timeout, rsp_fmt, rsp_plb, cyc);
          chk("rsp_valid", 64'(rsp_valid), 64'(1 << e.idx));
          chk("rsp_allow", 64'(rsp_allow), 64'(e.allow));
          chk("rsp_fault", 64'(rsp_fault), 64'(e.fault));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
          if (e.chk_data) begin
            chk("rsp_format", 64'(rsp_fmt), 64'(e.fmt));
            chk("rsp_plb", rsp_plb, e.plb);
          end
          if (e.cyc >= 0) chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic wait_ready(output int t0);
    t0 = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        t0 = cyc;
        break;
      end
    end
    if (t0 < 0) bound_fail("ready_wait");
  endtask

  task automatic wait_rsp(input int target, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_seen >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bound_fail("rsp_wait");
  endtask

  task automatic do_reset();
    rst_n = 0;
    req_valid = '0;
    flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_flush", 64'(ptw_flush), 64'd0);
    chk("rst_enable", 64'(ptw_enable), 64'd0);
    chk("rst_addr_valid", 64'(ptw_addr_valid), 64'd0);
    chk("rst_rsp_data", {rsp_plb[59:0], rsp_allow, rsp_fault, rsp_timeout, 1'b0}, 64'd0);
    chk("rst_spa", 64'(ptw_spa), 64'd0);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    int t0, base, f0, a0;
    exp_t e;

    do_reset();

    // Single request from requester 0, walker answers after 5 WAIT cycles.
    w_silent = 0; w_delay = 5; w_valid = 1; w_fault = 0; w_allow = 1; w_fmt = '0;
    w_plb = 64'h1234_5678_9abc_def0;
    req_spa[0*SW +: SW] = 34'h0_8000_1000;
    req_access[1:0] = 2'b01;
    grant_q.push_back(0);
    base = rsp_seen;
    @(posedge clk); #1 req_valid = 2'b01;
    wait_ready(t0);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    chk("issue_addr_valid", 64'(ptw_addr_valid), 64'd1);
    chk("issue_cycle", 64'(cyc), 64'(t0 + 1));
    chk("issue_spa", 64'(ptw_spa), 64'h0_8000_1000);
    chk("issue_access", 64'(ptw_access), 64'd1);
    chk("issue_enable", 64'(ptw_enable), 64'd1);
    wait_rsp(base + 1, 40);

    // Valid and fault in the same cycle: fault wins, format code passes through.
    w_delay = 3; w_valid = 1; w_fault = 1; w_allow = 1; w_fmt = 3'd3;
    w_plb = 64'hdead_beef_0000_0001;
    req_spa[1*SW +: SW] = 34'h3_ffff_f000;
    req_access[3:2] = 2'b10;
    grant_q.push_back(1);
    base = rsp_seen;
    @(posedge clk); #1 req_valid = 2'b10;
    wait_ready(t0);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    chk("issue_spa_r1", 64'(ptw_spa), 64'h3_ffff_f000);
    wait_rsp(base + 1, 40);

    // Silent walker: timeout fault after 255 WAIT cycles, one flush pulse.
    w_silent = 1; w_fault = 0; w_fmt = '0;
    grant_q.push_back(0);
    e.idx = 0; e.allow = 0; e.fault = 1; e.tmo = 1; e.fmt = '0; e.plb = '0;
    e.cyc = -1; e.chk_data = 0;
    rsp_q.push_back(e);
    f0 = flush_pulses;
    base = rsp_seen;
    @(posedge clk); #1 req_valid = 2'b01;
    wait_ready(t0);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(base + 1, 400);
    chk("timeout_flush_pulses", 64'(flush_pulses - f0), 64'd1);

    // Flush in the 3rd WAIT cycle, with requester 1 pending.
    grant_q.push_back(0);
    @(posedge clk); #1 req_valid = 2'b01;
    wait_ready(t0);
    @(posedge clk); #1 req_valid = 2'b10;
    @(negedge clk);
    chk("flush_issue", 64'(ptw_addr_valid), 64'd1);
    repeat (3) @(posedge clk);
    #1 flush = 1;
    w_silent = 0; w_delay = 1; w_valid = 1; w_fault = 0; w_allow = 1;
    w_plb = 64'h0000_0000_cafe_f00d;
    grant_q.push_back(1);
    base = rsp_seen;
    @(negedge clk);
    chk("flush_fwd", 64'(ptw_flush), 64'd1);
    chk("flush_no_rsp", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("flush_then_grant1", 64'(req_ready), 64'b10);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(base + 1, 40);
    chk("flush_rsp_count", 64'(rsp_seen - base), 64'd1);

    // Bypass with MPT disabled: response the cycle after acceptance, no walk.
    mpt_en = 0;
    a0 = addrv_cnt;
    grant_q.push_back(1);
    base = rsp_seen;
    @(posedge clk); #1 req_valid = 2'b10;
    wait_ready(t0);
    e.idx = 1; e.allow = 1; e.fault = 0; e.tmo = 0; e.fmt = '0; e.plb = '0;
    e.cyc = t0 + 1; e.chk_data = 1;
    rsp_q.push_back(e);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(base + 1, 20);
    chk("bypass_no_addr_valid", 64'(addrv_cnt - a0), 64'd0);
    mpt_en = 1;

    // Both requesters valid from reset: grants alternate 0,1,0,1.
    do_reset();
    w_silent = 0; w_delay = 2; w_valid = 1; w_fault = 0; w_allow = 1; w_fmt = '0;
    w_plb = 64'h0000_0000_0000_00aa;
    grant_q.push_back(0); grant_q.push_back(1);
    grant_q.push_back(0); grant_q.push_back(1);
    base = rsp_seen;
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) wait_ready(t0);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(base + 4, 40);

    repeat (3) @(negedge clk);
    chk("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
    chk("grant_queue_empty", 64'(grant_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation bound expired");
    $fatal(1);
  end

endmodule
